// File: rtl/dmi_resp_serializer.sv
// DMI response serializer: pops 34-bit responses and shifts them out LSB-first.
// Optional even-parity trailer bit when DMI_RESP_SER_PARITY_EN is defined.
module dmi_resp_serializer #(
  parameter int GAP_CYCLES = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  logic [33:0]          fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 ser_valid_o,
  output logic                 ser_data_o,
  output logic                 ser_last_o,
  input  logic                 ser_ready_i,
  output logic                 busy_o,
  input  logic                 err_clr_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

`ifdef DMI_RESP_SER_PARITY_EN
  localparam int N = 35;
`else
  localparam int N = 34;
`endif

  localparam logic [5:0] LAST_BIT = 6'(N - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [33:0]          sreg;
  logic [5:0]           bit_cnt;
  logic [3:0]           gap_cnt;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 pop;
  logic                 accept;
  logic                 last_bit;
  logic                 gap_done;
  logic                 cur_bit;

`ifdef DMI_RESP_SER_PARITY_EN
  logic par;
`endif

  // Reset gates the pop so the FIFO is untouched while held in reset.
  assign pop      = (state == IDLE) && !fifo_empty_i
                    && !flush_i && !rst_i;
  assign accept   = (state == SHIFT) && ser_ready_i;
  assign last_bit = (bit_cnt == LAST_BIT);
  assign gap_done = (gap_cnt == GAP_LAST);

`ifdef DMI_RESP_SER_PARITY_EN
  assign cur_bit = (bit_cnt == 6'd34) ? par : sreg[0];
`else
  assign cur_bit = sreg[0];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) state_nxt = SHIFT;
        end
        SHIFT: begin
          if (accept && last_bit) begin
            state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_done) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_pop_o  = pop;
    ser_valid_o = (state == SHIFT);
    ser_data_o  = (state == SHIFT) && cur_bit;
    ser_last_o  = (state == SHIFT) && last_bit;
    busy_o      = (state != IDLE);
    err_cnt_o   = err_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg    <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (pop) begin
        sreg    <= fifo_data_i;
        bit_cnt <= '0;
      end else if (accept) begin
        sreg    <= {1'b0, sreg[33:1]};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (state == SHIFT) begin
        gap_cnt <= '0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end
    end
  end

`ifdef DMI_RESP_SER_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par <= 1'b0;
    end else if (pop) begin
      par <= ^fifo_data_i;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt <= '0;
    end else if (err_clr_i) begin
      err_cnt <= '0;
    end else if (pop && (fifo_data_i[1:0] != 2'b00)
                 && !(&err_cnt)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmi_resp_serializer.sv
// Directed testbench for dmi_resp_serializer with a queue-based FIFO model.
// Covers the parity trailer when DMI_RESP_SER_PARITY_EN is defined.
module tb_dmi_resp_serializer;

`ifdef DMI_RESP_SER_PARITY_EN
  localparam int N = 35;
`else
  localparam int N = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        fifo_empty_i;
  logic [33:0] fifo_data_i;
  logic        fifo_pop_o;
  logic        ser_valid_o;
  logic        ser_data_o;
  logic        ser_last_o;
  logic        ser_ready_i;
  logic        busy_o;
  logic        err_clr_i;
  logic [7:0]  err_cnt_o;

  int checks = 0;
  int failures = 0;
  logic [33:0] q[$];
  bit pend;

  dmi_resp_serializer #(.GAP_CYCLES(1), .ERR_CNT_W(8)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i(fifo_data_i),
    .fifo_pop_o(fifo_pop_o),
    .ser_valid_o(ser_valid_o),
    .ser_data_o(ser_data_o),
    .ser_last_o(ser_last_o),
    .ser_ready_i(ser_ready_i),
    .busy_o(busy_o),
    .err_clr_i(err_clr_i),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic view();
    fifo_empty_i = (q.size() == 0);
    fifo_data_i  = (q.size() == 0) ? 34'd0 : q[0];
  endtask

  task automatic push(input logic [33:0] v);
    q.push_back(v);
    view();
  endtask

  // One clock edge; the FIFO model pops if pop was high before the edge.
  task automatic tick();
    pend = (fifo_pop_o === 1'b1);
    @(posedge clk);
    if (pend && q.size() > 0) q.delete(0);
    #1;
    view();
  endtask

  task automatic collect(input bit toggle,
                         output logic [34:0] bits,
                         output int nbits, output int shifts,
                         output int last_at, output int last_cnt,
                         output int pops, output bit timeout);
    bit acc;
    bit lst;
    bits = '0; nbits = 0; shifts = 0;
    last_at = -1; last_cnt = 0; pops = 0; timeout = 1'b1;
    for (int k = 0; k < 200; k++) begin
      ser_ready_i = toggle ? (k % 2 == 1) : 1'b1;
      #1;
      if (fifo_pop_o === 1'b1) pops++;
      if (ser_valid_o === 1'b1) shifts++;
      lst = (ser_last_o === 1'b1);
      if (lst) last_cnt++;
      acc = (ser_valid_o === 1'b1) && ser_ready_i;
      if (acc && nbits < 35) begin
        bits[nbits] = ser_data_o;
        if (lst) last_at = nbits;
        nbits++;
      end
      tick();
      if (acc && nbits == N) begin
        timeout = 1'b0;
        break;
      end
    end
    ser_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    push({32'hDEADBEEF, 2'b00});
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if ({fifo_pop_o, ser_valid_o, ser_data_o, ser_last_o, busy_o} !== 5'b0
          || err_cnt_o !== 8'd0) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d got pop=%b v=%b d=%b l=%b busy=%b err=%0d want all 0",
                 i, fifo_pop_o, ser_valid_o, ser_data_o, ser_last_o, busy_o, err_cnt_o);
      end
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (fifo_pop_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_pop got %b want 1", fifo_pop_o);
    end
  endtask

  task automatic test_single_frame();
    logic [34:0] b;
    int nb, sh, la, lc, pp;
    bit to;
    tick();
    collect(1'b0, b, nb, sh, la, lc, pp, to);
    checks++;
    if (to || nb != N || b[33:0] !== {32'hDEADBEEF, 2'b00}) begin
      failures++;
      $display("FAIL single_bits got n=%0d bits=%h want n=%0d bits=%h",
               nb, b[33:0], N, {32'hDEADBEEF, 2'b00});
    end
    checks++;
    if (sh != N || la != N - 1 || lc != 1 || pp != 0) begin
      failures++;
      $display("FAIL single_timing got shifts=%0d last_at=%0d lasts=%0d pops=%0d want %0d %0d 1 0",
               sh, la, lc, pp, N, N - 1);
    end
    #1;
    checks++;
    if (busy_o !== 1'b1 || ser_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_gap got busy=%b valid=%b want 1 0", busy_o, ser_valid_o);
    end
    tick();
    #1;
    checks++;
    if (busy_o !== 1'b0 || err_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL single_idle got busy=%b err=%0d want 0 0", busy_o, err_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] b;
    int nb, sh, la, lc, pp;
    bit to;
    push({32'hDEADBEEF, 2'b00});
    #1;
    tick();
    push({32'h0F0F1234, 2'b00});
    collect(1'b1, b, nb, sh, la, lc, pp, to);
    checks++;
    if (to || nb != N || b[33:0] !== {32'hDEADBEEF, 2'b00}) begin
      failures++;
      $display("FAIL bp_bits got n=%0d bits=%h want n=%0d bits=%h",
               nb, b[33:0], N, {32'hDEADBEEF, 2'b00});
    end
    checks++;
    if (sh != 2 * N || pp != 0) begin
      failures++;
      $display("FAIL bp_shift_cycles got shifts=%0d pops=%0d want %0d 0", sh, pp, 2 * N);
    end
    #1;
    checks++;
    if (fifo_pop_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_gap_nopop got pop=%b busy=%b want 0 1", fifo_pop_o, busy_o);
    end
    tick();
    #1;
    checks++;
    if (fifo_pop_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle_pop got pop=%b busy=%b want 1 0", fifo_pop_o, busy_o);
    end
    tick();
    collect(1'b0, b, nb, sh, la, lc, pp, to);
    checks++;
    if (to || nb != N || b[33:0] !== {32'h0F0F1234, 2'b00}) begin
      failures++;
      $display("FAIL bp_second_bits got n=%0d bits=%h want n=%0d bits=%h",
               nb, b[33:0], N, {32'h0F0F1234, 2'b00});
    end
    tick();
  endtask

  task automatic test_back_to_back(input bit with_clr, input int exp_err);
    int t[3];
    int np;
    bit done;
    np = 0;
    done = 1'b0;
    ser_ready_i = 1'b1;
    push({32'h11111111, 2'd2});
    push({32'h22222222, 2'd0});
    push({32'h33333333, 2'd3});
    for (int k = 0; k < 400; k++) begin
      err_clr_i = with_clr && np == 2 && busy_o === 1'b0 && !fifo_empty_i;
      #1;
      if (fifo_pop_o === 1'b1 && np < 3) begin
        t[np] = k;
        np++;
      end
      tick();
      if (np == 3 && busy_o === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    err_clr_i = 1'b0;
    checks++;
    if (!done || t[1] - t[0] != N + 2 || t[2] - t[1] != N + 2) begin
      failures++;
      $display("FAIL b2b_period clr=%0d got done=%0d pops=%0d gaps=%0d,%0d want %0d",
               with_clr, done, np, t[1] - t[0], t[2] - t[1], N + 2);
    end
    #1;
    checks++;
    if (err_cnt_o !== 8'(exp_err)) begin
      failures++;
      $display("FAIL b2b_err clr=%0d got %0d want %0d", with_clr, err_cnt_o, exp_err);
    end
  endtask

  task automatic test_flush();
    logic [34:0] b;
    logic [33:0] x;
    int nb, sh, la, lc, pp;
    bit to;
    x = {32'hCAFEF00D, 2'b01};
    ser_ready_i = 1'b1;
    push(x);
    push({32'h000000F0, 2'b10});
    #1;
    tick();
    repeat (10) tick();
    flush_i = 1'b1;
    #1;
    checks++;
    if (ser_valid_o !== 1'b1 || ser_data_o !== x[10] || fifo_pop_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle got v=%b d=%b pop=%b want 1 %b 0",
               ser_valid_o, ser_data_o, fifo_pop_o, x[10]);
    end
    tick();
    flush_i = 1'b0;
    #1;
    checks++;
    if (ser_valid_o !== 1'b0 || busy_o !== 1'b0 || fifo_pop_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_after got v=%b busy=%b pop=%b want 0 0 1",
               ser_valid_o, busy_o, fifo_pop_o);
    end
    tick();
    collect(1'b0, b, nb, sh, la, lc, pp, to);
    checks++;
    if (to || nb != N || b[33:0] !== {32'h000000F0, 2'b10}) begin
      failures++;
      $display("FAIL flush_restart got n=%0d bits=%h want n=%0d bits=%h",
               nb, b[33:0], N, {32'h000000F0, 2'b10});
    end
    tick();
    #1;
    checks++;
    if (err_cnt_o !== 8'd2) begin
      failures++;
      $display("FAIL flush_err got %0d want 2", err_cnt_o);
    end
  endtask

`ifdef DMI_RESP_SER_PARITY_EN
  task automatic test_parity();
    logic [34:0] b;
    int nb, sh, la, lc, pp;
    bit to;
    push({32'h00000001, 2'b01});
    #1;
    tick();
    collect(1'b0, b, nb, sh, la, lc, pp, to);
    checks++;
    if (to || nb != 35 || b !== {1'b0, 32'h00000001, 2'b01}) begin
      failures++;
      $display("FAIL parity_bits got n=%0d bits=%h want 35 %h",
               nb, b, {1'b0, 32'h00000001, 2'b01});
    end
    checks++;
    if (la != 34 || lc != 1) begin
      failures++;
      $display("FAIL parity_last got last_at=%0d lasts=%0d want 34 1", la, lc);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    ser_ready_i = 1'b1;
    push({32'h00000003, 2'b11});
    #1;
    tick();
    repeat (5) tick();
    #1;
    checks++;
    if (err_cnt_o !== 8'd3 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre got err=%0d busy=%b want 3 1", err_cnt_o, busy_o);
    end
    rst_i = 1'b1;
    flush_i = 1'b1;
    tick();
    #1;
    checks++;
    if ({fifo_pop_o, ser_valid_o, ser_data_o, ser_last_o, busy_o} !== 5'b0
        || err_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got pop=%b v=%b d=%b l=%b busy=%b err=%0d want all 0",
               fifo_pop_o, ser_valid_o, ser_data_o, ser_last_o, busy_o, err_cnt_o);
    end
    rst_i = 1'b0;
    flush_i = 1'b0;
    tick();
    #1;
    checks++;
    if (busy_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
      failures++;
      $display("FAIL empty_idle got busy=%b pop=%b want 0 0", busy_o, fifo_pop_o);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    ser_ready_i = 1'b1;
    err_clr_i = 1'b0;
    pend = 1'b0;
    view();
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back(1'b0, 2);
    test_back_to_back(1'b1, 0);
    test_flush();
`ifdef DMI_RESP_SER_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
